// File: rtl/div5_serial_scheduler_if.sv
// Requester/scheduler bundle: two operand requests in, grants and divide-by-5 verdict out.
// The residue signal exists only when DIV5_RESIDUE_OUT_EN is defined.
interface div5_serial_scheduler_if #(
  parameter int WIDTH = 8
);
  logic             req0;
  logic             req1;
  logic [WIDTH-1:0] data0;
  logic [WIDTH-1:0] data1;
  logic             gnt0;
  logic             gnt1;
  logic             busy;
  logic             done;
  logic             done_id;
  logic             divisible;
`ifdef DIV5_RESIDUE_OUT_EN
  logic [2:0]       residue;
`endif

  modport master (
    output req0, req1, data0, data1,
`ifdef DIV5_RESIDUE_OUT_EN
    input  residue,
`endif
    input  gnt0, gnt1, busy, done, done_id, divisible
  );

  modport slave (
    input  req0, req1, data0, data1,
`ifdef DIV5_RESIDUE_OUT_EN
    output residue,
`endif
    output gnt0, gnt1, busy, done, done_id, divisible
  );
endinterface

// File: rtl/div5_serial_scheduler.sv
// Round-robin two-requester serial divisibility-by-5 checker (MSB first); DIV5_RESIDUE_OUT_EN adds residue output.
// Latency: grant in T, done in T+WIDTH+1, next grant no earlier than T+WIDTH+2.
// Backpressure: requests are only seen in IDLE; an ungranted req stays pending until a later IDLE.
module div5_serial_scheduler #(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  div5_serial_scheduler_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] shreg;
  logic [2:0]       res;
  logic [2:0]       res_nx;
  logic [3:0]       dbl;
  logic [CW-1:0]    cnt;
  logic             last_bit;
  logic             last_id;
  logic             owner;
  logic             done_id_q;
  logic             div_q;
  logic             g0;
  logic             g1;
`ifdef DIV5_RESIDUE_OUT_EN
  logic [2:0]       res_q;
`endif

  // {res, bit} is exactly 2*res+bit (0..9), so one conditional subtract keeps it in 0..4
  always_comb begin
    dbl    = {res, shreg[WIDTH-1]};
    res_nx = (dbl >= 4'd5) ? 3'(dbl - 4'd5) : dbl[2:0];
  end

  assign last_bit = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    g0       = 1'b0;
    g1       = 1'b0;
    unique case (state)
      IDLE: begin
        // gated by reset so grants drop the instant reset rises
        if (!reset) begin
          if (bus.req1 && (!bus.req0 || !last_id)) g1 = 1'b1;
          else if (bus.req0)                       g0 = 1'b1;
        end
        if (g0 || g1) state_nx = SHIFT;
      end
      SHIFT: if (last_bit) state_nx = DONE;
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg     <= '0;
      res       <= 3'd0;
      cnt       <= '0;
      last_id   <= 1'b1;
      owner     <= 1'b0;
      done_id_q <= 1'b0;
      div_q     <= 1'b0;
`ifdef DIV5_RESIDUE_OUT_EN
      res_q     <= 3'd0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (g0 || g1) begin
            shreg   <= g1 ? bus.data1 : bus.data0;
            res     <= 3'd0;
            cnt     <= '0;
            owner   <= g1;
            last_id <= g1;
          end
        end
        SHIFT: begin
          shreg <= shreg << 1;
          res   <= res_nx;
          cnt   <= cnt + CW'(1);
          // verdict registered on entry to DONE so it is valid during the done pulse and held after
          if (last_bit) begin
            div_q     <= (res_nx == 3'd0);
            done_id_q <= owner;
`ifdef DIV5_RESIDUE_OUT_EN
            res_q     <= res_nx;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.gnt0      = g0;
  assign bus.gnt1      = g1;
  assign bus.busy      = (state != IDLE);
  assign bus.done      = (state == DONE);
  assign bus.done_id   = done_id_q;
  assign bus.divisible = div_q;
`ifdef DIV5_RESIDUE_OUT_EN
  assign bus.residue   = res_q;
`endif
endmodule

// File: tb/tb_div5_serial_scheduler.sv
// Bench for div5_serial_scheduler: cycle-accurate timing model plus directed literal checks.
module tb_div5_serial_scheduler;
  localparam int W = 8;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  div5_serial_scheduler_if #(.WIDTH(W)) bif();
  div5_serial_scheduler #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bif));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: the block is free from m_free onward; a grant at c owns the block until c+W+2
  // and produces its verdict at c+W+1 from the operand value seen at c.
  int             m_free = 0;
  bit             m_last = 1'b1;
  bit             m_fly  = 1'b0;
  int             m_dcyc = 0;
  logic [W-1:0]   m_val  = '0;
  bit             m_gid  = 1'b0;
  bit             m_div  = 1'b0;
  bit             m_id   = 1'b0;
  int             m_res  = 0;

  always @(negedge clk) begin : model
    bit eg0, eg1, ebusy, edone, id;
    if (reset) begin
      m_free = 0; m_last = 1'b1; m_fly = 1'b0;
      m_div = 1'b0; m_id = 1'b0; m_res = 0;
      chk("rst_gnt0", bif.gnt0, 0);
      chk("rst_gnt1", bif.gnt1, 0);
      chk("rst_busy", bif.busy, 0);
      chk("rst_done", bif.done, 0);
      chk("rst_done_id", bif.done_id, 0);
      chk("rst_divisible", bif.divisible, 0);
`ifdef DIV5_RESIDUE_OUT_EN
      chk("rst_residue", bif.residue, 0);
`endif
    end else begin
      ebusy = (cyc < m_free);
      eg0 = 1'b0; eg1 = 1'b0;
      if (!ebusy && (bif.req0 || bif.req1)) begin
        id     = (bif.req0 && bif.req1) ? ~m_last : bif.req1;
        eg0    = ~id;
        eg1    = id;
        m_fly  = 1'b1;
        m_dcyc = cyc + W + 1;
        m_val  = id ? bif.data1 : bif.data0;
        m_gid  = id;
        m_free = cyc + W + 2;
        m_last = id;
      end
      edone = m_fly && (cyc == m_dcyc);
      if (edone) begin
        m_fly = 1'b0;
        m_res = int'(m_val) % 5;
        m_div = (m_res == 0);
        m_id  = m_gid;
      end
      chk("m_gnt0", bif.gnt0, eg0);
      chk("m_gnt1", bif.gnt1, eg1);
      chk("m_busy", bif.busy, ebusy);
      chk("m_done", bif.done, edone);
      chk("m_done_id", bif.done_id, m_id);
      chk("m_divisible", bif.divisible, m_div);
`ifdef DIV5_RESIDUE_OUT_EN
      chk("m_residue", bif.residue, m_res);
`endif
    end
  end

  task automatic wait_gnt(output int t, output bit g);
    t = -1; g = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bif.gnt0 || bif.gnt1) begin
        t = cyc; g = bif.gnt1;
        return;
      end
    end
    chk("gnt_timeout", 0, 1);
  endtask

  task automatic wait_done(output int t);
    t = -1000;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bif.done) begin
        t = cyc;
        return;
      end
    end
    chk("done_timeout", 0, 1);
  endtask

  task automatic check_result(input string tag, input int lat, input bit id, input logic [2:0] eres);
    chk({tag, "_latency"}, lat, W + 1);
    chk({tag, "_divisible"}, bif.divisible, (eres == 3'd0));
    chk({tag, "_done_id"}, bif.done_id, id);
`ifdef DIV5_RESIDUE_OUT_EN
    chk({tag, "_residue"}, bif.residue, eres);
`endif
  endtask

  task automatic run_op(input string tag, input bit id, input logic [7:0] val, input logic [2:0] eres);
    int t, d;
    bit g;
    @(posedge clk); #1;
    if (id) begin bif.req1 = 1'b1; bif.data1 = val; end
    else    begin bif.req0 = 1'b1; bif.data0 = val; end
    wait_gnt(t, g);
    chk({tag, "_gnt_id"}, g, id);
    @(posedge clk); #1;
    bif.req0 = 1'b0; bif.req1 = 1'b0;
    wait_done(d);
    check_result(tag, d - t, id, eres);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin : stim
    int t1, t2, d;
    bit g;
    // both requesters held from reset: 0xFF then 0x00
    bif.req0 = 1'b1; bif.req1 = 1'b1;
    bif.data0 = 8'hFF; bif.data1 = 8'h00;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    wait_gnt(t1, g);
    chk("both_first_is0", g, 0);
    @(posedge clk); #1 bif.req0 = 1'b0;
    wait_done(d);
    check_result("both_op0", d - t1, 1'b0, 3'd0);
    wait_gnt(t2, g);
    chk("both_second_is1", g, 1);
    chk("both_gap", t2 - t1, 10);
    @(posedge clk); #1 bif.req1 = 1'b0;
    wait_done(d);
    check_result("both_op1", d - t2, 1'b1, 3'd0);

    run_op("d0_0f", 1'b0, 8'h0F, 3'd0);
    run_op("d1_10", 1'b1, 8'h10, 3'd1);
    run_op("d0_05", 1'b0, 8'h05, 3'd0);

    // contention after serving 0: requester 1 must win first
    @(posedge clk); #1;
    bif.req0 = 1'b1; bif.req1 = 1'b1; bif.data0 = 8'h19; bif.data1 = 8'h32;
    wait_gnt(t1, g);
    chk("rr_first_is1", g, 1);
    @(posedge clk); #1 bif.req1 = 1'b0;
    wait_done(d);
    check_result("rr_op1", d - t1, 1'b1, 3'd0);
    wait_gnt(t2, g);
    chk("rr_second_is0", g, 0);
    @(posedge clk); #1 bif.req0 = 1'b0;
    wait_done(d);
    check_result("rr_op0", d - t2, 1'b0, 3'd0);

    // operand changed mid-flight must not disturb result
    @(posedge clk); #1;
    bif.req0 = 1'b1; bif.data0 = 8'hFE;
    wait_gnt(t1, g);
    chk("chg_gnt_id", g, 0);
    @(posedge clk); #1 bif.req0 = 1'b0;
    repeat (2) @(posedge clk);
    #1 bif.data0 = 8'h00;
    wait_done(d);
    check_result("chg", d - t1, 1'b0, 3'd4);

    // reset at T+4 aborts an operation
    run_op("pre_abort", 1'b1, 8'h0A, 3'd0);
    @(posedge clk); #1;
    bif.req0 = 1'b1; bif.data0 = 8'h33;
    wait_gnt(t1, g);
    @(posedge clk); #1 bif.req0 = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("abort_busy", bif.busy, 0);
    chk("abort_done", bif.done, 0);
    chk("abort_done_id", bif.done_id, 0);
    chk("abort_divisible", bif.divisible, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("abort_no_done", bif.done, 0);
    end
    run_op("post_abort", 1'b0, 8'h14, 3'd0);

    for (int v = 0; v < 256; v++)
      run_op("sweep", v[0], 8'(v), 3'(v % 5));

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
